// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and register file of the pipelined MIPS core.
// Other pipeline stages and the bench import the register index names from here.
package wb_regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_CNT_W  = 32;

    localparam int unsigned REG_ZERO = 32'd0;
    localparam int unsigned REG_SP   = 32'd29;
    localparam int unsigned REG_RA   = 32'd31;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_rf_read_port.sv
// One ID-stage read port: the hard-wired zero register wins first.
// Otherwise the in-flight WB write is bypassed, and failing that the stored value is used.
module rf_read_port
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic              i_byp_en,
    input  logic [ADDR_W-1:0] i_byp_addr,
    input  logic [DATA_W-1:0] i_byp_data,
    output logic [DATA_W-1:0] o_rd_data
);

    // Read-data select with zero-register and bypass priority
    always_comb begin
        o_rd_data = {DATA_W{1'b0}};
        if (i_addr == ADDR_W'(REG_ZERO)) begin
            o_rd_data = {DATA_W{1'b0}};
        end else if (i_byp_en && (i_byp_addr == i_addr)) begin
            o_rd_data = i_byp_data;
        end else begin
            o_rd_data = i_store_data;
        end
    end

endmodule : rf_read_port

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: selects MDR/ALUOut, commits on the clock
// edge, serves two bypassed ID read ports, a raw debug port and a committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_reg_write,
    input  logic              wb_memto_reg,
    input  logic [DATA_W-1:0] wb_mdr,
    input  logic [DATA_W-1:0] wb_alu_out,
    input  logic [ADDR_W-1:0] wb_wr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we_eff,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  commit_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [CNT_W-1:0]  r_commit_cnt;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_we_eff;
    logic [DATA_W-1:0] w_dbg_data;

    // Upstream resets only RegWrite, so the data fields may be X; only w_we_eff gates state.
    assign w_wb_data = wb_memto_reg ? wb_mdr : wb_alu_out;
    assign w_we_eff  = wb_reg_write && (wb_wr_addr != ADDR_W'(REG_ZERO));

    // Register storage: async clear, then one committed write per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (w_we_eff) begin
            r_regs[wb_wr_addr] <= w_wb_data;
        end
    end

    // Committed-write counter, wraps modulo 2**CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_cnt <= {CNT_W{1'b0}};
        end else if (w_we_eff) begin
            r_commit_cnt <= r_commit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Debug port sees storage only, so a write shows up the cycle after it commits
    always_comb begin
        w_dbg_data = {DATA_W{1'b0}};
        if (dbg_addr == ADDR_W'(REG_ZERO)) begin
            w_dbg_data = {DATA_W{1'b0}};
        end else begin
            w_dbg_data = r_regs[dbg_addr];
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs_port (
        .i_addr       (rs_addr),
        .i_store_data (r_regs[rs_addr]),
        .i_byp_en     (w_we_eff),
        .i_byp_addr   (wb_wr_addr),
        .i_byp_data   (w_wb_data),
        .o_rd_data    (rs_data)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rt_port (
        .i_addr       (rt_addr),
        .i_store_data (r_regs[rt_addr]),
        .i_byp_en     (w_we_eff),
        .i_byp_addr   (wb_wr_addr),
        .i_byp_data   (w_wb_data),
        .o_rd_data    (rt_data)
    );

    assign wb_data    = w_wb_data;
    assign wb_we_eff  = w_we_eff;
    assign dbg_data   = w_dbg_data;
    assign commit_cnt = r_commit_cnt;

endmodule : wb_regfile
